// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer that streams operand bits LSB-first through an external
// 1-bit adder_subtractor cell. Optional signed overflow flag: define OVERFLOW_FLAG_EN.
module serial_addsub_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ts_out,
`ifdef OVERFLOW_FLAG_EN
    output logic             overflow,
`endif
    output logic             cell_M,
    output logic             cell_A,
    output logic             cell_B,
    output logic             cell_Te,
    input  logic             cell_S,
    input  logic             cell_Ts
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             te_q, te_d;
    logic             ts_out_q, ts_out_d;
`ifdef OVERFLOW_FLAG_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             overflow_q, overflow_d;
    logic             ovf_add, ovf_sub;

    // Final S bit is the result MSB, so overflow is resolved on the last RUN edge.
    assign ovf_add = (a_msb_q == b_msb_q) && (cell_S != a_msb_q);
    assign ovf_sub = (a_msb_q != b_msb_q) && (cell_S != a_msb_q);
`endif

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        te_d      = te_q;
        ts_out_d  = ts_out_q;
`ifdef OVERFLOW_FLAG_EN
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        overflow_d = overflow_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_a_d = op_a;
                    shift_b_d = op_b;
                    mode_d    = mode;
                    te_d      = 1'b0;
                    cnt_d     = '0;
                    state_d   = StRun;
`ifdef OVERFLOW_FLAG_EN
                    a_msb_d   = op_a[WIDTH-1];
                    b_msb_d   = op_b[WIDTH-1];
`endif
                end
            end
            StRun: begin
                result_d  = {cell_S, result_q[WIDTH-1:1]};
                te_d      = cell_Ts;
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    ts_out_d = cell_Ts;
`ifdef OVERFLOW_FLAG_EN
                    overflow_d = mode_q ? ovf_sub : ovf_add;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_a_q <= '0;
            shift_b_q <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            te_q      <= 1'b0;
            ts_out_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            te_q      <= te_d;
            ts_out_q  <= ts_out_d;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign ts_out  = ts_out_q;
`ifdef OVERFLOW_FLAG_EN
    assign overflow = overflow_q;
`endif
    assign cell_M  = mode_q;
    assign cell_A  = shift_a_q[0];
    assign cell_B  = shift_b_q[0];
    assign cell_Te = te_q;

endmodule
